// File: rtl/tick_div_bank.sv
// -----------------------------------------------------------------------------
// tick_div_bank
//
// A bank of CH programmable dividers that share one clock. Each channel emits a
// one-cycle clock-enable pulse (tick) every N cycles of clk_100m, where N is
// the channel's active divisor. It can also drive a square wave (sq).
// Downstream logic stays in the clk_100m domain and uses tick as an enable.
// tick is not a derived clock.
//
// Divisors can be reloaded at run time. A load only writes a pending
// register. The pending value is copied into the active divisor at a period
// boundary (wrap), on sync_clr, or on any cycle while the channel is disabled.
// A period that is already running therefore always finishes with its old N.
//
// Optional feature (compile-time macro TICK_DIV_SQ_EN):
//   defined   - sq flops present. sq rises with tick and falls floor(N/2)
//               enabled edges later.
//   undefined - no sq flops. The sq port is tied to 0. tick is unchanged.
//
// Parameters:
//   CH       number of channels
//   CW       divisor / counter width, N <= 2^CW-1
//   DIV_RST  packed CH x CW reset divisors, channel 0 in the LSBs
//
// Ports:
//   clk_100m  in   1   system clock. All state updates on the rising edge.
//   cr        in   1   asynchronous active-high clear. Restores DIV_RST.
//   en        in   1   global count enable
//   sync_clr  in   1   synchronous phase realign of every channel
//   ld        in   1   divisor load strobe
//   ld_sel    in   CH  channels written by ld
//   div_in    in   CW  divisor value written by ld
//   tick      out  CH  registered one-cycle pulse per channel
//   sq        out  CH  registered square wave per channel
//
// Every output is taken straight from a flop. No input has a combinational
// path to an output.
// -----------------------------------------------------------------------------
module tick_div_bank #(
   parameter int unsigned        CH      = 3,
   parameter int unsigned        CW      = 27,
   parameter logic [CH*CW-1:0]   DIV_RST = {27'd100000000, 27'd200000, 27'd100000}
) (
   input  logic          clk_100m,
   input  logic          cr,
   input  logic          en,
   input  logic          sync_clr,
   input  logic          ld,
   input  logic [CH-1:0] ld_sel,
   input  logic [CW-1:0] div_in,
   output logic [CH-1:0] tick,
   output logic [CH-1:0] sq
);

   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   for (genvar i = 0; i < CH; i++) begin : g_ch

      localparam logic [CW-1:0] RST_DIV = DIV_RST[i*CW +: CW];

      logic [CW-1:0] div_act_q,  div_act_d;
      logic [CW-1:0] div_pend_q, div_pend_d;
      logic [CW-1:0] cnt_q,      cnt_d;
      logic          tick_q,     tick_d;

      logic          disabled;
      logic          realign;
      logic          wrap;

      // A zero divisor parks the channel. It keeps copying the pending divisor
      // so that a nonzero load starts it on the next cycle from cnt = 0.
      assign disabled = (div_act_q == '0);

      // sync_clr and the disabled state do the same thing: clear the phase and
      // adopt the pending divisor. sync_clr has priority over en and wrap.
      assign realign  = sync_clr || disabled;

      // Period boundary. cnt never exceeds div_act-1 because div_act only
      // changes while cnt is 0, so equality is enough here.
      assign wrap     = en && !disabled && (cnt_q == div_act_q - ONE);

      // Pending divisor. Written by ld even during sync_clr. The value written
      // in this cycle is never the one applied by this cycle's wrap or realign,
      // because both of those read div_pend_q.
      always_comb begin
         div_pend_d = div_pend_q;
         if (ld && ld_sel[i]) begin
            div_pend_d = div_in;
         end
      end

      always_comb begin
         div_act_d = div_act_q;
         cnt_d     = cnt_q;
         tick_d    = 1'b0;
         if (realign) begin
            div_act_d = div_pend_q;
            cnt_d     = '0;
         end else if (wrap) begin
            div_act_d = div_pend_q;
            cnt_d     = '0;
            tick_d    = 1'b1;
         end else if (en) begin
            cnt_d     = cnt_q + ONE;
         end
      end

      always_ff @(posedge clk_100m or posedge cr) begin
         if (cr) begin
            div_act_q  <= RST_DIV;
            div_pend_q <= RST_DIV;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
         end else begin
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
         end
      end

      assign tick[i] = tick_q;

`ifdef TICK_DIV_SQ_EN
      logic          sq_q, sq_d;
      logic [CW-1:0] half_act;

      assign half_act = div_act_q >> 1;

      // sq rises at the wrap that starts a new period. The new period uses the
      // divisor being loaded, so sq only rises when that divisor is >= 2.
      // With N = 1 the high phase would be zero cycles, so sq stays low.
      // sq falls on the enabled edge that moves cnt to floor(N/2). While en is
      // low, cnt does not move, so sq holds its level.
      always_comb begin
         sq_d = sq_q;
         if (realign) begin
            sq_d = 1'b0;
         end else if (wrap) begin
            sq_d = (div_pend_q > ONE);
         end else if (en && (cnt_q + ONE == half_act)) begin
            sq_d = 1'b0;
         end
      end

      always_ff @(posedge clk_100m or posedge cr) begin
         if (cr) begin
            sq_q <= 1'b0;
         end else begin
            sq_q <= sq_d;
         end
      end

      assign sq[i] = sq_q;
`else
      assign sq[i] = 1'b0;
`endif

   end : g_ch

endmodule : tick_div_bank

// File: tb/tb_tick_div_bank.sv
// -----------------------------------------------------------------------------
// tb_tick_div_bank
//
// Bench for tick_div_bank. It uses a narrow counter (CW = 8) and small reset
// divisors, so reset defaults and the 2^CW-1 boundary fit into short runs.
//
// The reference model tracks, for each channel:
//   - the active divisor,
//   - the pending divisor,
//   - the edges elapsed in the current period,
//   - whether a tick has occurred since the last realign.
// Expected tick and sq values are derived from these with plain arithmetic.
// Directed scenarios also compare tick positions against hand-derived
// constants.
//
// When TICK_DIV_SQ_EN is defined, sq is modelled as described in the RTL.
// When it is undefined, sq is expected to be 0.
// -----------------------------------------------------------------------------
module tb_tick_div_bank;

   localparam int CH = 3;
   localparam int CW = 8;
   localparam logic [CH*CW-1:0] DIV_RST = {8'd50, 8'd20, 8'd10};

`ifdef TICK_DIV_SQ_EN
   localparam int SQ_ON = 1;
`else
   localparam int SQ_ON = 0;
`endif

   // ---------------- clock / DUT ----------------
   logic          clk_100m = 1'b0;
   logic          cr;
   logic          en;
   logic          sync_clr;
   logic          ld;
   logic [CH-1:0] ld_sel;
   logic [CW-1:0] div_in;
   logic [CH-1:0] tick;
   logic [CH-1:0] sq;

   always #5 clk_100m = ~clk_100m;

   tick_div_bank #(
      .CH      (CH),
      .CW      (CW),
      .DIV_RST (DIV_RST)
   ) dut (
      .clk_100m (clk_100m),
      .cr       (cr),
      .en       (en),
      .sync_clr (sync_clr),
      .ld       (ld),
      .ld_sel   (ld_sel),
      .div_in   (div_in),
      .tick     (tick),
      .sq       (sq)
   );

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   int            m_act[CH];
   int            m_pend[CH];
   int            m_pos[CH];
   bit            m_started[CH];
   logic [CH-1:0] m_tick;
   logic [CH-1:0] m_sq;

   task automatic model_reset();
      logic [CH*CW-1:0] rst_vec;
      rst_vec = DIV_RST;
      for (int i = 0; i < CH; i++) begin
         m_act[i]     = int'(rst_vec[i*CW +: CW]);
         m_pend[i]    = m_act[i];
         m_pos[i]     = 0;
         m_started[i] = 1'b0;
      end
      m_tick = '0;
      m_sq   = '0;
   endtask

   // Advance the model by one rising edge, using the inputs currently driven.
   task automatic model_edge();
      int pend_old;
      for (int i = 0; i < CH; i++) begin
         pend_old = m_pend[i];
         if (ld && ld_sel[i]) m_pend[i] = int'(div_in);
         if (sync_clr || m_act[i] == 0) begin
            m_act[i]     = pend_old;
            m_pos[i]     = 0;
            m_started[i] = 1'b0;
            m_tick[i]    = 1'b0;
         end else if (!en) begin
            m_tick[i] = 1'b0;
         end else if (m_pos[i] + 1 == m_act[i]) begin
            m_tick[i]    = 1'b1;
            m_pos[i]     = 0;
            m_act[i]     = pend_old;
            m_started[i] = 1'b1;
         end else begin
            m_pos[i]  = m_pos[i] + 1;
            m_tick[i] = 1'b0;
         end
         // sq is high for the first floor(N/2) positions of every period that
         // began with a tick.
         m_sq[i] = (SQ_ON == 1) && m_started[i] && (m_pos[i] < m_act[i] / 2);
      end
   endtask

   // ---------------- driver ----------------
   // Drive the inputs, take one rising edge, update the model, and return
   // 1 time unit after the edge so that outputs are stable when sampled.
   task automatic step(input logic s_en, input logic s_ld, input logic [CH-1:0] s_sel,
                       input logic [CW-1:0] s_din, input logic s_clr);
      en       = s_en;
      ld       = s_ld;
      ld_sel   = s_sel;
      div_in   = s_din;
      sync_clr = s_clr;
      @(posedge clk_100m);
      model_edge();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int n[CH];
      cr = 1'b1; en = 1'b0; ld = 1'b0; ld_sel = '0; div_in = '0; sync_clr = 1'b0;
      repeat (3) @(posedge clk_100m);
      #1;
      checks++;
      if (tick !== '0 || sq !== '0) begin
         failures++;
         $display("FAIL reset_outputs: tick=%b sq=%b expected 000/000", tick, sq);
      end
      model_reset();
      cr = 1'b0;
      for (int i = 0; i < CH; i++) n[i] = 0;
      for (int e = 1; e <= 60; e++) begin
         step(1'b1, 1'b0, '0, '0, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL reset_run edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         for (int i = 0; i < CH; i++) n[i] += int'(tick[i]);
      end
      checks++;
      if (n[0] != 6 || n[1] != 3 || n[2] != 1) begin
         failures++;
         $display("FAIL reset_tick_counts: got %0d/%0d/%0d expected 6/3/1", n[0], n[1], n[2]);
      end
   endtask

   task automatic test_small_div();
      logic [63:0] tv, ev;
      int sq_hi;
      // N = 5 on channel 0
      step(1'b1, 1'b1, 3'b001, 8'd5, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b1);
      tv = '0; sq_hi = 0;
      for (int e = 1; e <= 25; e++) begin
         step(1'b1, 1'b0, '0, '0, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL small5 edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         if (tick[0] === 1'b1) tv[e] = 1'b1;
         if (e >= 5 && e <= 24 && sq[0] === 1'b1) sq_hi++;
      end
      ev = '0;
      for (int k = 5; k <= 25; k += 5) ev[k] = 1'b1;
      checks++;
      if (tv !== ev) begin
         failures++;
         $display("FAIL small5_ticks: got %h expected %h", tv, ev);
      end
      checks++;
      if (sq_hi != 8 * SQ_ON) begin
         failures++;
         $display("FAIL small5_sq_duty: got %0d high cycles expected %0d", sq_hi, 8 * SQ_ON);
      end
      // N = 4 on channel 0
      step(1'b1, 1'b1, 3'b001, 8'd4, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b1);
      tv = '0; sq_hi = 0;
      for (int e = 1; e <= 24; e++) begin
         step(1'b1, 1'b0, '0, '0, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL small4 edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         if (tick[0] === 1'b1) tv[e] = 1'b1;
         if (e >= 4 && e <= 23 && sq[0] === 1'b1) sq_hi++;
      end
      ev = '0;
      for (int k = 4; k <= 24; k += 4) ev[k] = 1'b1;
      checks++;
      if (tv !== ev) begin
         failures++;
         $display("FAIL small4_ticks: got %h expected %h", tv, ev);
      end
      checks++;
      if (sq_hi != 10 * SQ_ON) begin
         failures++;
         $display("FAIL small4_sq_duty: got %0d high cycles expected %0d", sq_hi, 10 * SQ_ON);
      end
   endtask

   task automatic test_reload();
      logic [63:0] tv, ev;
      // Load 3 while cnt = 2. The running 8-cycle period completes first.
      step(1'b1, 1'b1, 3'b001, 8'd8, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b1);
      tv = '0;
      for (int e = 1; e <= 20; e++) begin
         step(1'b1, (e == 3), 3'b001, 8'd3, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL reload_mid edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         if (tick[0] === 1'b1) tv[e] = 1'b1;
      end
      ev = '0; ev[8] = 1'b1; ev[11] = 1'b1; ev[14] = 1'b1; ev[17] = 1'b1; ev[20] = 1'b1;
      checks++;
      if (tv !== ev) begin
         failures++;
         $display("FAIL reload_mid_ticks: got %h expected %h", tv, ev);
      end
      // Load 3 on the wrap edge. One more 8-cycle period runs first.
      step(1'b1, 1'b1, 3'b001, 8'd8, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b1);
      tv = '0;
      for (int e = 1; e <= 25; e++) begin
         step(1'b1, (e == 8), 3'b001, 8'd3, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL reload_wrap edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         if (tick[0] === 1'b1) tv[e] = 1'b1;
      end
      ev = '0; ev[8] = 1'b1; ev[16] = 1'b1; ev[19] = 1'b1; ev[22] = 1'b1; ev[25] = 1'b1;
      checks++;
      if (tv !== ev) begin
         failures++;
         $display("FAIL reload_wrap_ticks: got %h expected %h", tv, ev);
      end
   endtask

   task automatic test_enable();
      logic [63:0] tv, ev;
      int sq_hi;
      // en low for 7 edges during the high phase of sq
      step(1'b1, 1'b1, 3'b001, 8'd8, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b1);
      tv = '0; sq_hi = 0;
      for (int e = 1; e <= 31; e++) begin
         step(!(e >= 10 && e <= 16), 1'b0, '0, '0, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL stall edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         if (tick[0] === 1'b1) tv[e] = 1'b1;
         if (e >= 9 && e <= 16 && sq[0] === 1'b1) sq_hi++;
      end
      ev = '0; ev[8] = 1'b1; ev[23] = 1'b1; ev[31] = 1'b1;
      checks++;
      if (tv !== ev) begin
         failures++;
         $display("FAIL stall_ticks: got %h expected %h", tv, ev);
      end
      checks++;
      if (sq_hi != 8 * SQ_ON) begin
         failures++;
         $display("FAIL stall_sq_hold: got %0d high cycles expected %0d", sq_hi, 8 * SQ_ON);
      end
      // Load 0: the current period ends with one tick, then the channel is silent.
      tv = '0; sq_hi = 0;
      for (int e = 1; e <= 20; e++) begin
         step(1'b1, (e == 1), 3'b001, 8'd0, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL disable edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         if (tick[0] === 1'b1) tv[e] = 1'b1;
         if (e >= 9 && sq[0] === 1'b1) sq_hi++;
      end
      ev = '0; ev[8] = 1'b1;
      checks++;
      if (tv !== ev || sq_hi != 0) begin
         failures++;
         $display("FAIL disable_ticks: got %h sq_hi=%0d expected %h sq_hi=0", tv, sq_hi, ev);
      end
      // Load 2 while disabled. The channel restarts from cnt = 0 on the next cycle.
      tv = '0;
      for (int e = 1; e <= 10; e++) begin
         step(1'b1, (e == 1), 3'b001, 8'd2, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL resume edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         if (tick[0] === 1'b1) tv[e] = 1'b1;
      end
      ev = '0; ev[4] = 1'b1; ev[6] = 1'b1; ev[8] = 1'b1; ev[10] = 1'b1;
      checks++;
      if (tv !== ev) begin
         failures++;
         $display("FAIL resume_ticks: got %h expected %h", tv, ev);
      end
   endtask

   task automatic test_boundaries();
      logic [63:0] tv, ev;
      int n_t, first_e, sq_hi;
      // N = 1
      step(1'b1, 1'b1, 3'b001, 8'd1, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b1);
      n_t = 0; sq_hi = 0;
      for (int e = 1; e <= 10; e++) begin
         step(1'b1, 1'b0, '0, '0, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL n1 edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         n_t += int'(tick[0]);
         sq_hi += int'(sq[0]);
      end
      checks++;
      if (n_t != 10 || sq_hi != 0) begin
         failures++;
         $display("FAIL n1_constant: got ticks=%0d sq_hi=%0d expected 10/0", n_t, sq_hi);
      end
      // N = 2^CW-1
      step(1'b1, 1'b1, 3'b001, 8'd255, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b1);
      n_t = 0; first_e = -1;
      for (int e = 1; e <= 260; e++) begin
         step(1'b1, 1'b0, '0, '0, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL nmax edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         if (tick[0] === 1'b1) begin
            n_t++;
            if (first_e < 0) first_e = e;
         end
      end
      checks++;
      if (n_t != 1 || first_e != 255) begin
         failures++;
         $display("FAIL nmax_ticks: got count=%0d first=%0d expected 1/255", n_t, first_e);
      end
      // Assert cr mid-operation after loads. Divisors return to DIV_RST.
      step(1'b1, 1'b1, 3'b111, 8'd7, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b1);
      for (int e = 1; e <= 7; e++) step(1'b1, 1'b0, '0, '0, 1'b0);
      #2;
      cr = 1'b1;
      #1;
      checks++;
      if (tick !== '0 || sq !== '0) begin
         failures++;
         $display("FAIL cr_async: tick=%b sq=%b expected 000/000", tick, sq);
      end
      model_reset();
      #1;
      cr = 1'b0;
      tv = '0;
      for (int e = 1; e <= 60; e++) begin
         step(1'b1, 1'b0, '0, '0, 1'b0);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL cr_revert edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
         if (tick[0] === 1'b1) tv[e] = 1'b1;
      end
      ev = '0;
      for (int k = 10; k <= 60; k += 10) ev[k] = 1'b1;
      checks++;
      if (tv !== ev) begin
         failures++;
         $display("FAIL cr_revert_ticks: got %h expected %h", tv, ev);
      end
   endtask

   task automatic test_random();
      logic          r_en, r_ld, r_clr;
      logic [CH-1:0] r_sel;
      logic [CW-1:0] r_din;
      for (int e = 1; e <= 1500; e++) begin
         r_en  = ($urandom_range(0, 9) != 0);
         r_ld  = ($urandom_range(0, 9) == 0);
         r_sel = CH'($urandom_range(0, 7));
         r_din = CW'($urandom_range(0, 12));
         r_clr = ($urandom_range(0, 49) == 0);
         step(r_en, r_ld, r_sel, r_din, r_clr);
         checks++;
         if (tick !== m_tick || sq !== m_sq) begin
            failures++;
            $display("FAIL random edge %0d: tick=%b sq=%b expected tick=%b sq=%b", e, tick, sq, m_tick, m_sq);
         end
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_small_div();
      test_reload();
      test_enable();
      test_boundaries();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_tick_div_bank
